dot_product_st: RTL and testbench
=================================

# dot_product_st

Streaming fixed-point dot-product engine for the classifier datapath. Each beat it consumes `PARALLEL` pixel/weight pairs, multiplies them in a pipelined lane array, reduces them through a pipelined adder tree and accumulates the result. After exactly `PIXEL_N` elements it freezes and holds the final sum on `value` until the next reset. It sits between the pixel/weight streaming fetch logic and the per-class score comparison.

## Interface
- `PIXEL_N`, 785: number of elements in one dot product.
- `WEIGHT_SIZE`, 19: weight width, signed two's complement Q2.16 (sign, 2 integer bits, 16 fraction bits).
- `PIXEL_SIZE`, 10: pixel width, unsigned integer.
- `FPM_DELAY`, 6: multiplier pipeline depth in register stages, ≥1.
- `FPA_DELAY`, 2: register stages per adder-tree level, ≥1.
- `PARALLEL`, 4: lanes per bus slot, a power of two.
- `BUS_WIDTH`, 1: bus slots per beat; one beat is held for `BUS_WIDTH` cycles.
- `VAL_SIZE`, 26: result width, signed Q7.18 (26 bits total, 18 fraction bits).
- `clk`, input, 1: rising-edge clock.
- `GlobalReset`, input, 1: asynchronous, active-low reset.
- `Pixels`, input, `BUS_WIDTH*PARALLEL*PIXEL_SIZE`: lane n is at `[n*PIXEL_SIZE +: PIXEL_SIZE]`.
- `Weights`, input, `BUS_WIDTH*PARALLEL*WEIGHT_SIZE`: lane n is at `[n*WEIGHT_SIZE +: WEIGHT_SIZE]`.
- `value`, output, `VAL_SIZE`: accumulator register, driven directly.

## Operation
- No handshake. After `GlobalReset` is released, the first rising edge is sampling cycle 0.
- In cycle c, the block uses slot `k = c mod BUS_WIDTH`, which is lanes `k*PARALLEL` to `k*PARALLEL+PARALLEL-1`. Element index = c*PARALLEL + lane.
- Element counter: counts up to `PIXEL_N` and then saturates there.
  - Lanes whose element index is ≥ `PIXEL_N` are forced to zero before the multiplier.
  - After the counter saturates, all inputs are ignored.
- Multiply:
  - Signed weight × zero-extended pixel gives a signed product with 16 fraction bits.
  - Sign-extend it and shift left by 2 to align to 18 fraction bits at `VAL_SIZE` width.
- Reduce: a binary adder tree of log2(`PARALLEL`) levels, at `VAL_SIZE` width, with modular addition inside the tree.
- Accumulate: accumulator register = accumulator + tree output, updated every cycle.
  - Zero-masked lanes and drained pipeline bubbles contribute 0, so `value` stays stable once the stream is done.
- Overflow behaviour on accumulation is set by Configuration.
- Reset at any time, including mid-stream, asynchronously clears the accumulator, all pipeline registers and the counter. A new stream then starts at cycle 0 after release.

## Timing
- Reset value of `value` is 0.
- Latency: `L = FPM_DELAY + FPA_DELAY*log2(PARALLEL) + 1`. With the defaults, L = 11.
- The contribution of sampling cycle c is visible on `value` after the clock edge at cycle c+L.
- Final sum is valid from cycle `ceil(PIXEL_N/PARALLEL) - 1 + L`, which is 207 with the defaults, and is held indefinitely.
- Partially accumulated values are visible on `value` before that point. Consumers must wait for the final cycle.

## Configuration
- `DOT_PRODUCT_SATURATE_EN` defined: the accumulator saturates.
  - Clamps to `0x1FFFFFF` on positive overflow and `0x2000000` on negative overflow.
  - Once clamped, the value stays clamped in that direction unless a later addition brings it back into range.
- Not defined: the accumulator wraps modulo 2^`VAL_SIZE`.

## Structure
- Package `dot_product_pkg` holds:
  - Q-format constants: weight fraction bits 16, value fraction bits 18, alignment shift 2.
  - A `clog2`-based latency function.
  - Saturation limit constants.
- Sub-module `dp_adder_tree`: parameterized by width, lane count and `FPA_DELAY`; pipelined reduction with asynchronous active-low reset.
- The top level holds the lane multipliers with their `FPM_DELAY` shift registers, the slot and element counter, and the accumulator.

## Test plan
- Default stream: pixel i = i%3, all weights `19'h08000` (0.5), true sum 392.
  - Without the macro, `value` = `26'h2200000`.
  - With `DOT_PRODUCT_SATURATE_EN`, `value` = `26'h1FFFFFF`, stable for 30 cycles after cycle 207.
- Single element: element 0 has pixel 4 and weight 0.5, everything else is 0.
  - `value` = 0 through cycle 10.
  - `value` = `26'h0080000` (2.0) from cycle 11 onward.
- Negative weight: element 0 has pixel 2 and weight `19'h78000` (-0.5), everything else is 0. Expect `value` = `26'h3FC0000` (-1.0).
- Reset mid-stream: assert `GlobalReset` low at beat 100, then replay the full default stream. Expect `value` = 0 during reset and the same final result as the first scenario.
- Post-stream garbage: drive pixel 1023 and weight `19'h3FFFF` on all lanes after beat 196. Expect `value` unchanged from the first scenario.
- Configuration sweep: `PARALLEL`=8, `BUS_WIDTH`=2, `PIXEL_N`=16, all pixels 1, weights 0.5.
  - Expect `value` = `26'h0200000` (8.0).
  - Expect latency `FPM_DELAY + 3*FPA_DELAY + 1`.

Source files
------------

// File: rtl/dot_product_pkg.sv
// dot_product_pkg: Q-format constants, latency and saturation helpers for dot_product_st.
// Rev 1.0
`default_nettype none

package dot_product_pkg;

  localparam int c_weight_frac = 16;
  localparam int c_value_frac  = 18;
  localparam int c_align_shift = c_value_frac - c_weight_frac;

  // Cycles from sampling a beat to its contribution appearing on the accumulator.
  function automatic int dp_latency(input int fpm_delay, input int fpa_delay, input int lanes);
    return fpm_delay + fpa_delay * $clog2(lanes) + 1;
  endfunction

  // Largest positive two's complement value of the given width.
  function automatic logic [63:0] sat_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value of the given width.
  function automatic logic [63:0] sat_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dp_adder_tree.sv
// dp_adder_tree: pipelined binary reduction of LANES values, FPA_DELAY registers per level.
// Rev 1.0
`default_nettype none

module dp_adder_tree #(
  parameter int WIDTH     = 26,
  parameter int LANES     = 4,
  parameter int FPA_DELAY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] lanes,
  output logic [WIDTH-1:0]       sum
);

  localparam int c_levels = $clog2(LANES);
  localparam int c_nodes  = 2 * LANES - 1;

  // All tree nodes packed level by level: leaves first, root last.
  logic [c_nodes*WIDTH-1:0] w_node;

  assign w_node[LANES*WIDTH-1:0] = lanes;

  for (genvar l = 1; l <= c_levels; l++) begin : g_level
    localparam int c_cnt = LANES >> l;
    localparam int c_src = 2 * LANES - 2 * (LANES >> (l - 1));
    localparam int c_dst = 2 * LANES - 2 * c_cnt;

    logic [c_cnt*WIDTH-1:0] w_sum;
    logic [c_cnt*WIDTH-1:0] r_pipe [FPA_DELAY];

    for (genvar n = 0; n < c_cnt; n++) begin : g_node
      assign w_sum[n*WIDTH +: WIDTH] = w_node[(c_src + 2*n)*WIDTH +: WIDTH]
                                     + w_node[(c_src + 2*n + 1)*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < FPA_DELAY; s++) r_pipe[s] <= '0;
      end else begin
        r_pipe[0] <= w_sum;
        for (int s = 1; s < FPA_DELAY; s++) r_pipe[s] <= r_pipe[s-1];
      end
    end

    assign w_node[c_dst*WIDTH +: c_cnt*WIDTH] = r_pipe[FPA_DELAY-1];
  end

  assign sum = w_node[(c_nodes-1)*WIDTH +: WIDTH];

endmodule

`default_nettype wire

// File: rtl/dot_product_st.sv
// dot_product_st: streaming fixed-point dot product, holds the final sum once PIXEL_N elements are in.
// Rev 1.0 -- DOT_PRODUCT_SATURATE_EN selects a saturating accumulator (default: wrapping).
`default_nettype none

module dot_product_st
  import dot_product_pkg::*;
#(
  parameter int PIXEL_N     = 785,
  parameter int WEIGHT_SIZE = 19,
  parameter int PIXEL_SIZE  = 10,
  parameter int FPM_DELAY   = 6,
  parameter int FPA_DELAY   = 2,
  parameter int PARALLEL    = 4,
  parameter int BUS_WIDTH   = 1,
  parameter int VAL_SIZE    = 26
) (
  input  logic                                  clk,
  input  logic                                  GlobalReset,
  input  logic [BUS_WIDTH*PARALLEL*PIXEL_SIZE-1:0]  Pixels,
  input  logic [BUS_WIDTH*PARALLEL*WEIGHT_SIZE-1:0] Weights,
  output logic [VAL_SIZE-1:0]                   value
);

  localparam int c_prod_w = WEIGHT_SIZE + PIXEL_SIZE + 1;
  localparam int c_ext_w  = (c_prod_w + c_align_shift > VAL_SIZE) ? c_prod_w + c_align_shift : VAL_SIZE;
  localparam int c_cnt_w  = $clog2(PIXEL_N + 1);
  localparam int c_slot_w = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

  logic [c_cnt_w-1:0]           r_elem_cnt;
  logic [31:0]                  w_cnt_step;
  logic [c_slot_w-1:0]          w_slot;
  logic [PARALLEL*VAL_SIZE-1:0] w_lane_flat;
  logic [PARALLEL*VAL_SIZE-1:0] r_mul_pipe [FPM_DELAY];
  logic [VAL_SIZE-1:0]          w_tree_sum;
  logic [VAL_SIZE-1:0]          w_acc_next;

  // Element counter saturates at PIXEL_N; from then on every lane is masked.
  assign w_cnt_step = 32'(r_elem_cnt) + 32'(PARALLEL);

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_elem_cnt <= '0;
    end else begin
      r_elem_cnt <= (w_cnt_step >= 32'(PIXEL_N)) ? c_cnt_w'(PIXEL_N) : c_cnt_w'(w_cnt_step);
    end
  end

  if (BUS_WIDTH > 1) begin : g_slot_cnt
    logic [c_slot_w-1:0] r_slot;

    always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
        r_slot <= '0;
      end else begin
        r_slot <= (r_slot == c_slot_w'(BUS_WIDTH - 1)) ? '0 : r_slot + c_slot_w'(1);
      end
    end

    assign w_slot = r_slot;
  end else begin : g_slot_fixed
    assign w_slot = '0;
  end

  for (genvar n = 0; n < PARALLEL; n++) begin : g_lane
    logic                       w_live;
    logic [PIXEL_SIZE-1:0]      r_pix;
    logic [WEIGHT_SIZE-1:0]     r_wgt;
    logic signed [c_prod_w-1:0] w_prod;

    assign w_live = (32'(r_elem_cnt) + 32'(n)) < 32'(PIXEL_N);

    always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
        r_pix <= '0;
        r_wgt <= '0;
      end else if (w_live) begin
        r_pix <= Pixels[(int'(w_slot)*PARALLEL + n)*PIXEL_SIZE +: PIXEL_SIZE];
        r_wgt <= Weights[(int'(w_slot)*PARALLEL + n)*WEIGHT_SIZE +: WEIGHT_SIZE];
      end else begin
        r_pix <= '0;
        r_wgt <= '0;
      end
    end

    // Q2.16 weight times unsigned pixel keeps 16 fraction bits; shift up to Q7.18.
    assign w_prod = c_prod_w'($signed(r_wgt)) * c_prod_w'($signed({1'b0, r_pix}));
    assign w_lane_flat[n*VAL_SIZE +: VAL_SIZE] = VAL_SIZE'(c_ext_w'(w_prod) <<< c_align_shift);
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      for (int s = 0; s < FPM_DELAY; s++) r_mul_pipe[s] <= '0;
    end else begin
      r_mul_pipe[0] <= w_lane_flat;
      for (int s = 1; s < FPM_DELAY; s++) r_mul_pipe[s] <= r_mul_pipe[s-1];
    end
  end

  dp_adder_tree #(
    .WIDTH     (VAL_SIZE),
    .LANES     (PARALLEL),
    .FPA_DELAY (FPA_DELAY)
  ) u_tree (
    .clk   (clk),
    .rst_n (GlobalReset),
    .lanes (r_mul_pipe[FPM_DELAY-1]),
    .sum   (w_tree_sum)
  );

`ifdef DOT_PRODUCT_SATURATE_EN
  localparam logic [VAL_SIZE-1:0] c_sat_hi = VAL_SIZE'(sat_pos(VAL_SIZE));
  localparam logic [VAL_SIZE-1:0] c_sat_lo = VAL_SIZE'(sat_neg(VAL_SIZE));

  logic [VAL_SIZE:0] w_acc_wide;

  // One guard bit: the top two bits disagree exactly when the sum left the signed range.
  assign w_acc_wide = {value[VAL_SIZE-1], value} + {w_tree_sum[VAL_SIZE-1], w_tree_sum};

  always_comb begin
    w_acc_next = w_acc_wide[VAL_SIZE-1:0];
    if (w_acc_wide[VAL_SIZE:VAL_SIZE-1] == 2'b01) begin
      w_acc_next = c_sat_hi;
    end else if (w_acc_wide[VAL_SIZE:VAL_SIZE-1] == 2'b10) begin
      w_acc_next = c_sat_lo;
    end
  end
`else
  assign w_acc_next = value + w_tree_sum;
`endif

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      value <= '0;
    end else begin
      value <= w_acc_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dot_product_st.sv
// tb_dot_product_st: directed vectors with hand-computed sums for dot_product_st.
// Rev 1.0
`default_nettype none

module tb_dot_product_st;

  localparam int P1  = 4;
  localparam int P2  = 8;
  localparam int BW2 = 2;

`ifdef DOT_PRODUCT_SATURATE_EN
  localparam logic [25:0] EXP_FINAL   = 26'h1FFFFFF;
  localparam logic [25:0] EXP_PARTIAL = 26'h1FFFFFF;
  localparam logic [25:0] EXP_B100    = 26'h1FFFFFF;
`else
  localparam logic [25:0] EXP_FINAL   = 26'h2200000;
  localparam logic [25:0] EXP_PARTIAL = 26'h21E0000;
  localparam logic [25:0] EXP_B100    = 26'h2D00000;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [P1*10-1:0]     pixels;
  logic [P1*19-1:0]     weights;
  logic [25:0]          value;

  logic                 rst2_n;
  logic [BW2*P2*10-1:0] pixels2;
  logic [BW2*P2*19-1:0] weights2;
  logic [25:0]          value2;

  logic [25:0] hist  [0:299];
  logic [25:0] hist2 [0:31];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dot_product_st #(
    .PIXEL_N(785), .WEIGHT_SIZE(19), .PIXEL_SIZE(10), .FPM_DELAY(6),
    .FPA_DELAY(2), .PARALLEL(P1), .BUS_WIDTH(1), .VAL_SIZE(26)
  ) dut (
    .clk(clk), .GlobalReset(rst_n), .Pixels(pixels), .Weights(weights), .value(value)
  );

  dot_product_st #(
    .PIXEL_N(16), .WEIGHT_SIZE(19), .PIXEL_SIZE(10), .FPM_DELAY(6),
    .FPA_DELAY(2), .PARALLEL(P2), .BUS_WIDTH(BW2), .VAL_SIZE(26)
  ) dut_sweep (
    .clk(clk), .GlobalReset(rst2_n), .Pixels(pixels2), .Weights(weights2), .value(value2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scenarios: 0 default ramp, 1 default with garbage after beat 196, 2 single element, 3 negative weight.
  task automatic set_inputs(input int scn, input int c);
    for (int n = 0; n < P1; n++) begin
      int e;
      logic [9:0]  p;
      logic [18:0] w;
      e = c * P1 + n;
      p = '0;
      w = '0;
      case (scn)
        0: begin p = 10'(e % 3); w = 19'h08000; end
        1: begin
          if (c > 196) begin p = 10'h3FF; w = 19'h3FFFF; end
          else begin p = 10'(e % 3); w = 19'h08000; end
        end
        2: if (e == 0) begin p = 10'd4; w = 19'h08000; end
        3: if (e == 0) begin p = 10'd2; w = 19'h78000; end
        default: ;
      endcase
      pixels[n*10 +: 10]  = p;
      weights[n*19 +: 19] = w;
    end
  endtask

  // Called on a negedge; leaves the DUT released so the next posedge is cycle 0.
  task automatic start_stream(input string tag);
    rst_n   = 1'b0;
    pixels  = '0;
    weights = '0;
    repeat (2) @(negedge clk);
    check({tag, "_reset"}, 64'(value), 64'h0);
    rst_n = 1'b1;
  endtask

  task automatic run_stream(input int scn, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      set_inputs(scn, c);
      @(posedge clk);
      @(negedge clk);
      hist[c] = value;
    end
  endtask

  task automatic run_sweep(input logic [9:0] slot1_pix, input logic [25:0] exp_first, input logic [25:0] exp_final);
    rst2_n = 1'b0;
    for (int s = 0; s < BW2; s++) begin
      for (int n = 0; n < P2; n++) begin
        pixels2[(s*P2 + n)*10 +: 10]  = (s == 1) ? slot1_pix : 10'd1;
        weights2[(s*P2 + n)*19 +: 19] = 19'h08000;
      end
    end
    repeat (2) @(negedge clk);
    check("sweep_reset", 64'(value2), 64'h0);
    rst2_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      hist2[c] = value2;
    end
    check("sweep_c12", 64'(hist2[12]), 64'h0);
    check("sweep_c13", 64'(hist2[13]), 64'(exp_first));
    check("sweep_c14", 64'(hist2[14]), 64'(exp_final));
    check("sweep_c29", 64'(hist2[29]), 64'(exp_final));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    rst2_n   = 1'b0;
    pixels   = '0;
    weights  = '0;
    pixels2  = '0;
    weights2 = '0;
    @(negedge clk);

    // Default ramp: latency edge, first beat, partial, final and hold.
    start_stream("dflt");
    run_stream(0, 240);
    check("dflt_c10", 64'(hist[10]), 64'h0);
    check("dflt_c11", 64'(hist[11]), 64'h60000);
    check("dflt_c100", 64'(hist[100]), 64'(EXP_B100));
    check("dflt_c206", 64'(hist[206]), 64'(EXP_PARTIAL));
    check("dflt_c207", 64'(hist[207]), 64'(EXP_FINAL));
    for (int c = 208; c <= 237; c++) begin
      check($sformatf("dflt_hold_c%0d", c), 64'(hist[c]), 64'(EXP_FINAL));
    end

    // Garbage after the stream must be ignored.
    start_stream("garb");
    run_stream(1, 240);
    check("garb_c207", 64'(hist[207]), 64'(EXP_FINAL));
    check("garb_c239", 64'(hist[239]), 64'(EXP_FINAL));

    start_stream("single");
    run_stream(2, 60);
    check("single_c5", 64'(hist[5]), 64'h0);
    check("single_c10", 64'(hist[10]), 64'h0);
    check("single_c11", 64'(hist[11]), 64'h0080000);
    check("single_c59", 64'(hist[59]), 64'h0080000);

    start_stream("neg");
    run_stream(3, 60);
    check("neg_c10", 64'(hist[10]), 64'h0);
    check("neg_c11", 64'(hist[11]), 64'h3FC0000);
    check("neg_c59", 64'(hist[59]), 64'h3FC0000);

    // Reset asserted between edges after beat 100, then a full replay.
    start_stream("mid");
    run_stream(0, 101);
    check("mid_c100", 64'(hist[100]), 64'(EXP_B100));
    #2 rst_n = 1'b0;
    #1 check("mid_async_clear", 64'(value), 64'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_hold_rst_%0d", i), 64'(value), 64'h0);
    end
    rst_n = 1'b1;
    run_stream(0, 215);
    check("mid_c11", 64'(hist[11]), 64'h60000);
    check("mid_c206", 64'(hist[206]), 64'(EXP_PARTIAL));
    check("mid_c207", 64'(hist[207]), 64'(EXP_FINAL));
    check("mid_c214", 64'(hist[214]), 64'(EXP_FINAL));

    // PARALLEL=8, BUS_WIDTH=2, PIXEL_N=16: latency 13, final one cycle later.
    run_sweep(10'd1, 26'h0100000, 26'h0200000);
    run_sweep(10'd3, 26'h0100000, 26'h0400000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
